// File: rtl/diff_drive_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : diff_drive_pwm
//  Brief    : Differential-drive controller: steering/speed command to
//             slew-limited per-wheel duties and glitch-free PWM, with watchdog.
//  Revision : 1.0
// ============================================================================
module diff_drive_pwm #(
    parameter int STEERING_WIDTH  = 10,
    parameter int PWM_WIDTH       = 8,
    parameter int STEER_SHIFT     = 9,
    parameter int DEADBAND        = 8,
    parameter int RAMP_STEP       = 4,
    parameter int RAMP_INTERVAL   = 1,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [STEERING_WIDTH-1:0] i_steering,
    input  logic [PWM_WIDTH-1:0]      i_base_speed,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic                      o_left_pwm,
    output logic                      o_right_pwm,
    output logic [PWM_WIDTH-1:0]      o_left_duty,
    output logic [PWM_WIDTH-1:0]      o_right_duty,
    output logic                      o_timeout
);

    // One spare bit so the magnitude of the most-negative code is representable.
    localparam int MAG_W  = ((STEERING_WIDTH > STEER_SHIFT) ? STEERING_WIDTH : STEER_SHIFT) + 1;
    localparam int PROD_W = MAG_W + PWM_WIDTH;
    localparam int RI_W   = $clog2(RAMP_INTERVAL + 1);
    localparam int WD_W   = $clog2(WATCHDOG_CYCLES + 1);

    localparam logic [MAG_W-1:0]     C_MAX_STEER = MAG_W'(1) << STEER_SHIFT;
    localparam logic [MAG_W-1:0]     C_DEADBAND  = MAG_W'(DEADBAND);
    localparam logic [PWM_WIDTH-1:0] C_STEP      = PWM_WIDTH'(RAMP_STEP);
    localparam logic [RI_W-1:0]      C_RI_LAST   = RI_W'(RAMP_INTERVAL - 1);
    localparam logic [WD_W-1:0]      C_WD        = WD_W'(WATCHDOG_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                    state_q;
    logic                      ready_q;
    logic [STEERING_WIDTH-1:0] cmd_steer_q;
    logic [PWM_WIDTH-1:0]      cmd_base_q;
    logic [PWM_WIDTH-1:0]      tgt_left_q, tgt_right_q;
    logic [PWM_WIDTH-1:0]      duty_left_q, duty_right_q;
    logic [PWM_WIDTH-1:0]      shadow_left_q, shadow_right_q;
    logic [PWM_WIDTH-1:0]      pwm_cnt_q;
    logic                      pwm_left_q, pwm_right_q;
    logic [RI_W-1:0]           ramp_cnt_q;
    logic [WD_W-1:0]           wd_cnt_q;
    logic                      timeout_q;

    logic                      w_accept;
    logic                      w_steer_neg;
    logic [MAG_W-1:0]          w_steer_ext, w_steer_abs, w_steer_clamped, w_steer_mag;
    logic [PROD_W-1:0]         w_product, w_adj, w_base_ext;
    logic [PWM_WIDTH-1:0]      w_reduced;
    logic [PWM_WIDTH-1:0]      tgt_left_d, tgt_right_d;
    logic                      w_ramp_tick;
    logic [WD_W-1:0]           w_wd_inc;
    logic                      w_expire;
    logic [PWM_WIDTH-1:0]      w_shadow_left, w_shadow_right;

    assign w_accept = i_valid && ready_q;

    assign w_steer_neg     = cmd_steer_q[STEERING_WIDTH-1];
    assign w_steer_ext     = {{(MAG_W-STEERING_WIDTH){w_steer_neg}}, cmd_steer_q};
    assign w_steer_abs     = w_steer_neg ? ((~w_steer_ext) + MAG_W'(1)) : w_steer_ext;
    assign w_steer_clamped = (w_steer_abs > C_MAX_STEER) ? C_MAX_STEER : w_steer_abs;
    assign w_steer_mag     = (w_steer_clamped < C_DEADBAND) ? '0 : w_steer_clamped;

    assign w_product  = PROD_W'(w_steer_mag) * PROD_W'(cmd_base_q);
    assign w_adj      = w_product >> STEER_SHIFT;
    assign w_base_ext = PROD_W'(cmd_base_q);
    assign w_reduced  = (w_adj >= w_base_ext) ? '0 : (cmd_base_q - w_adj[PWM_WIDTH-1:0]);

    always_comb begin
        tgt_left_d  = cmd_base_q;
        tgt_right_d = cmd_base_q;
        if (w_steer_mag != '0) begin
            if (w_steer_neg) begin
                tgt_left_d = w_reduced;
            end else begin
                tgt_right_d = w_reduced;
            end
        end
    end

    assign w_ramp_tick = (ramp_cnt_q == C_RI_LAST);
    assign w_wd_inc    = wd_cnt_q + WD_W'(1);
    assign w_expire    = !w_accept && !timeout_q && (w_wd_inc == C_WD);

    // The period's compare value is captured as the counter passes zero.
    assign w_shadow_left  = (pwm_cnt_q == '0) ? duty_left_q  : shadow_left_q;
    assign w_shadow_right = (pwm_cnt_q == '0) ? duty_right_q : shadow_right_q;

    function automatic logic [PWM_WIDTH-1:0] ramp_toward(
        input logic [PWM_WIDTH-1:0] cur,
        input logic [PWM_WIDTH-1:0] tgt
    );
        logic [PWM_WIDTH-1:0] gap;
        gap = '0;
        if (cur < tgt) begin
            gap = tgt - cur;
            return (gap > C_STEP) ? (cur + C_STEP) : tgt;
        end
        gap = cur - tgt;
        return (gap > C_STEP) ? (cur - C_STEP) : tgt;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ready_q        <= 1'b1;
            cmd_steer_q    <= '0;
            cmd_base_q     <= '0;
            tgt_left_q     <= '0;
            tgt_right_q    <= '0;
            duty_left_q    <= '0;
            duty_right_q   <= '0;
            shadow_left_q  <= '0;
            shadow_right_q <= '0;
            pwm_cnt_q      <= '0;
            pwm_left_q     <= 1'b0;
            pwm_right_q    <= 1'b0;
            ramp_cnt_q     <= '0;
            wd_cnt_q       <= '0;
            timeout_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (w_accept) begin
                        state_q     <= ST_CALC;
                        ready_q     <= 1'b0;
                        cmd_steer_q <= i_steering;
                        cmd_base_q  <= i_base_speed;
                    end
                end
                ST_CALC: begin
                    state_q     <= ST_RUN;
                    ready_q     <= 1'b1;
                    tgt_left_q  <= tgt_left_d;
                    tgt_right_q <= tgt_right_d;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase

            if (w_expire) begin
                tgt_left_q  <= '0;
                tgt_right_q <= '0;
            end

            ramp_cnt_q <= w_ramp_tick ? '0 : (ramp_cnt_q + RI_W'(1));
            if (w_ramp_tick) begin
                duty_left_q  <= ramp_toward(duty_left_q, tgt_left_q);
                duty_right_q <= ramp_toward(duty_right_q, tgt_right_q);
            end

            // Counter saturates once expired; only an accepted command rearms it.
            if (w_accept) begin
                wd_cnt_q  <= '0;
                timeout_q <= 1'b0;
            end else if (!timeout_q) begin
                wd_cnt_q <= w_wd_inc;
                if (w_wd_inc == C_WD) begin
                    timeout_q <= 1'b1;
                end
            end

            pwm_cnt_q      <= pwm_cnt_q + PWM_WIDTH'(1);
            shadow_left_q  <= w_shadow_left;
            shadow_right_q <= w_shadow_right;
            pwm_left_q     <= (pwm_cnt_q < w_shadow_left);
            pwm_right_q    <= (pwm_cnt_q < w_shadow_right);
        end
    end

    assign o_ready      = ready_q;
    assign o_left_pwm   = pwm_left_q;
    assign o_right_pwm  = pwm_right_q;
    assign o_left_duty  = duty_left_q;
    assign o_right_duty = duty_right_q;
    assign o_timeout    = timeout_q;

endmodule
`default_nettype wire
